// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type and maximal-length Galois tap masks
package lfsr_pkg;
  typedef enum logic {IDLE, RUN} lfsr_state_e;
  localparam logic [7:0] TAPS_8 = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;
endpackage

// File: rtl/lfsr_galois_step.sv
// lfsr_galois_step: one right-shift Galois LFSR step
module lfsr_galois_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] nxt
);
  assign nxt = (q >> 1) ^ (q[0] ? taps : '0);
endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng: Galois LFSR random word source with loadable taps/seed and a valid/ready output slot
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEPS = 1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = TAPS_16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed,
  input  logic             load_taps,
  input  logic [WIDTH-1:0] taps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             cfg_err
);
  lfsr_state_e state;
  logic [WIDTH-1:0] q, tap_r, adv;
  logic fire, slot_free, taps_ok, seed_zero;
  assign fire = out_valid & out_ready;
  assign slot_free = !out_valid | out_ready;
  assign taps_ok = taps[WIDTH-1];
  assign seed_zero = seed == '0;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [WIDTH-1:0] cur, nxt;
    if (i == 0) begin : g_first
      assign cur = q;
    end else begin : g_next
      assign cur = g_step[i-1].nxt;
    end
    lfsr_galois_step #(.WIDTH(WIDTH)) u_step (.q(cur), .taps(tap_r), .nxt(nxt));
  end
  assign adv = g_step[STEPS-1].nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      q <= DEFAULT_SEED;
      tap_r <= DEFAULT_TAPS;
      out_valid <= 1'b0;
      out_data <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= en ? RUN : IDLE;
      cfg_err <= (load_taps && !taps_ok) || (load_seed && seed_zero);
      if (load_taps && taps_ok) tap_r <= taps;
      if (load_seed) begin
        q <= seed_zero ? DEFAULT_SEED : seed;
        out_valid <= 1'b0;
      end else if (state == RUN && slot_free) begin
        out_data <= q;
        out_valid <= 1'b1;
        q <= adv;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  assert property (@(posedge clk) disable iff (!rst_n) q != '0);
endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: directed checks of the LFSR stream, handshake, config loads and full period
module tb_lfsr_prng;
  logic clk = 0, rst_n = 0, en = 0, load_seed = 0, load_taps = 0, out_ready = 0;
  logic [15:0] seed = '0, taps = '0;
  logic v1, v2, ce1, ce2;
  logic [15:0] d1, d2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  lfsr_prng #(.WIDTH(16), .STEPS(1), .DEFAULT_TAPS(16'hB400), .DEFAULT_SEED(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_seed(load_seed), .seed(seed), .load_taps(load_taps),
    .taps(taps), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .cfg_err(ce1));
  lfsr_prng #(.WIDTH(16), .STEPS(2), .DEFAULT_TAPS(16'hB400), .DEFAULT_SEED(16'h0001)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load_seed(load_seed), .seed(seed), .load_taps(load_taps),
    .taps(taps), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .cfg_err(ce2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut;
    rst_n = 0; en = 0; load_seed = 0; load_taps = 0; out_ready = 0; seed = '0; taps = '0;
    tick;
    rst_n = 1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    #1;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset valid got %b want 0", v1); end
    checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL reset data got %h want 0000", d1); end
    checks++; if (ce1 !== 1'b0) begin errors++; $display("FAIL reset cfg_err got %b want 0", ce1); end
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL reset valid2 got %b want 0", v2); end
    reset_dut;
    out_ready = 1;
    tick; tick;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL idle no fill got %b want 0", v1); end
  endtask
  task automatic test_stream;
    logic [15:0] e [12];
    logic [15:0] e2 [7];
    e = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40,
          16'h05A0, 16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D};
    e2 = '{16'h0001, 16'h5A00, 16'h1680, 16'h05A0, 16'h0168, 16'h005A, 16'hB416};
    reset_dut;
    en = 1; out_ready = 1;
    tick;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL latency valid got %b want 0", v1); end
    for (int k = 0; k < 13; k++) begin
      tick;
      checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL stream[%0d] valid got %b want 1", k, v1); end
      if (k < 12) begin
        checks++; if (d1 !== e[k]) begin errors++; $display("FAIL stream[%0d] data got %h want %h", k, d1, e[k]); end
      end else begin
        checks++; if (d1 !== 16'hB416) begin errors++; $display("FAIL stream wrap data got %h want b416", d1); end
      end
      if (k < 7) begin
        checks++; if (d2 !== e2[k]) begin errors++; $display("FAIL steps2[%0d] data got %h want %h", k, d2, e2[k]); end
      end
    end
  endtask
  task automatic test_backpressure;
    reset_dut;
    en = 1; out_ready = 1;
    tick; tick; tick; tick;
    checks++; if (d1 !== 16'h5A00) begin errors++; $display("FAIL bp setup got %h want 5a00", d1); end
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (v1 !== 1'b1 || d1 !== 16'h5A00) begin errors++; $display("FAIL bp hold[%0d] got %b/%h want 1/5a00", k, v1, d1); end
    end
    out_ready = 1;
    tick;
    checks++; if (d1 !== 16'h2D00) begin errors++; $display("FAIL bp release0 got %h want 2d00", d1); end
    tick;
    checks++; if (d1 !== 16'h1680) begin errors++; $display("FAIL bp release1 got %h want 1680", d1); end
  endtask
  task automatic test_seed_load;
    reset_dut;
    en = 1; out_ready = 1;
    tick; tick;
    load_seed = 1; seed = 16'h0000;
    tick;
    load_seed = 0;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL zero seed flush got %b want 0", v1); end
    checks++; if (ce1 !== 1'b1) begin errors++; $display("FAIL zero seed cfg_err got %b want 1", ce1); end
    tick;
    checks++; if (d1 !== 16'h0001 || v1 !== 1'b1) begin errors++; $display("FAIL zero seed word got %b/%h want 1/0001", v1, d1); end
    checks++; if (ce1 !== 1'b0) begin errors++; $display("FAIL cfg_err pulse width got %b want 0", ce1); end
    tick;
    checks++; if (d1 !== 16'hB400) begin errors++; $display("FAIL zero seed next got %h want b400", d1); end
    load_seed = 1; seed = 16'h1234;
    tick;
    load_seed = 0;
    checks++; if (v1 !== 1'b0 || ce1 !== 1'b0) begin errors++; $display("FAIL good seed got %b/%b want 0/0", v1, ce1); end
    tick;
    checks++; if (d1 !== 16'h1234) begin errors++; $display("FAIL good seed word got %h want 1234", d1); end
    tick;
    checks++; if (d1 !== 16'h091A) begin errors++; $display("FAIL good seed next got %h want 091a", d1); end
    load_seed = 1; seed = 16'h0000; load_taps = 1; taps = 16'h3400;
    tick;
    load_seed = 0; load_taps = 0;
    checks++; if (ce1 !== 1'b1) begin errors++; $display("FAIL double reject cfg_err got %b want 1", ce1); end
    tick;
    checks++; if (ce1 !== 1'b0) begin errors++; $display("FAIL double reject pulse got %b want 0", ce1); end
    checks++; if (d1 !== 16'h0001) begin errors++; $display("FAIL double reject word got %h want 0001", d1); end
  endtask
  task automatic test_taps;
    logic [15:0] e [7];
    e = '{16'h0001, 16'hD008, 16'h6804, 16'h3402, 16'h1A01, 16'hDD08, 16'h6E84};
    reset_dut;
    en = 1; out_ready = 1; load_taps = 1; taps = 16'h3400;
    tick;
    load_taps = 0;
    checks++; if (ce1 !== 1'b1) begin errors++; $display("FAIL bad taps cfg_err got %b want 1", ce1); end
    tick; tick;
    checks++; if (d1 !== 16'hB400) begin errors++; $display("FAIL bad taps kept got %h want b400", d1); end
    reset_dut;
    en = 1; out_ready = 1; load_taps = 1; taps = 16'hD008;
    tick;
    load_taps = 0;
    checks++; if (ce1 !== 1'b0) begin errors++; $display("FAIL good taps cfg_err got %b want 0", ce1); end
    for (int k = 0; k < 7; k++) begin
      tick;
      checks++; if (d1 !== e[k]) begin errors++; $display("FAIL new taps[%0d] got %h want %h", k, d1, e[k]); end
    end
  endtask
  task automatic test_en_drop;
    reset_dut;
    en = 1; out_ready = 1;
    tick; tick;
    en = 0; out_ready = 0;
    tick; tick;
    checks++; if (v1 !== 1'b1 || d1 !== 16'h0001) begin errors++; $display("FAIL en drop hold got %b/%h want 1/0001", v1, d1); end
    out_ready = 1;
    tick;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL en drop consumed got %b want 0", v1); end
    tick; tick;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL en drop no fill got %b want 0", v1); end
  endtask
  task automatic test_reset_mid;
    reset_dut;
    en = 1; out_ready = 1;
    tick; tick; tick; tick;
    rst_n = 0;
    #1;
    checks++; if (v1 !== 1'b0 || d1 !== 16'h0000) begin errors++; $display("FAIL async reset got %b/%h want 0/0000", v1, d1); end
    tick;
    rst_n = 1;
  endtask
  task automatic test_full_period;
    int n = 0;
    bit zero = 0, found = 0;
    reset_dut;
    en = 1; out_ready = 1;
    tick; tick;
    for (int i = 0; i < 70000 && !found; i++) begin
      tick;
      n++;
      if (d1 === 16'h0000) zero = 1;
      if (d1 === 16'h0001) found = 1;
    end
    checks++; if (!found || n != 65535) begin errors++; $display("FAIL period got %0d want 65535", n); end
    checks++; if (zero) begin errors++; $display("FAIL zero state seen got 1 want 0"); end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_seed_load;
    test_taps;
    test_en_drop;
    test_reset_mid;
    test_full_period;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
